picosoc_timer: RTL

Programmable down-counting timer peripheral on the PicoSoC iomem bus, decoded at 0x09xx_xxxx alongside the other peripherals. It gives firmware a prescaled one-shot or periodic timeout, a free-running cycle counter for delays and timestamps, and a level interrupt into the PicoRV32 IRQ vector on bit 5, which is currently tied low. Firmware reaches it through iomem loads and stores; the SoC decoder gates `iomem_valid` with the address decode.

---
 rtl/picosoc_timer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/picosoc_timer.sv
// Down-counting timer with prescaler, free-running cycle counter and level IRQ on the PicoSoC iomem bus.
// Latency: one cycle; iomem_ready and iomem_rdata are registered and valid the cycle after the request edge.
// Backpressure: none; one access per two cycles, and a request held high during the ack cycle is not re-accepted.
//
// Ports:
//   clk, reset             : CPU clock, synchronous active-high reset
//   iomem_valid/wstrb/addr : request (already address-decoded), byte strobes (0 = read), word offset in addr[4:2]
//   iomem_wdata            : write data
//   iomem_rdata/ready      : read data and one-cycle completion pulse
//   irq_o                  : level interrupt, PENDING & IRQ_EN
module picosoc_timer #(
    parameter logic [15:0] PRESCALE_RESET = 16'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        iomem_ready,
    output logic        irq_o
);

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_LOAD     = 3'd1;
    localparam logic [2:0] REG_COUNT    = 3'd2;
    localparam logic [2:0] REG_STATUS   = 3'd3;
    localparam logic [2:0] REG_PRESCALE = 3'd4;
    localparam logic [2:0] REG_CYCLES   = 3'd5;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } bus_state_t;

    bus_state_t  state_q;
    bus_state_t  state_d;
    logic        do_access;

    logic        ctrl_en_q;
    logic        ctrl_periodic_q;
    logic        ctrl_irq_en_q;
    logic [31:0] load_q;
    logic [31:0] count_q;
    logic        pending_q;
    logic [15:0] prescale_q;
    logic [15:0] pcnt_q;
    logic [31:0] cycles_q;
    logic [31:0] rdata_q;

    logic [2:0]  reg_sel;
    logic        do_write;
    logic [31:0] wmask;
    logic        wr_ctrl;
    logic        wr_load;
    logic        wr_count;
    logic        wr_prescale;
    logic        clr_pending;
    logic        en_rise;
    logic        tick;
    logic        expire;
    logic [31:0] load_wr_val;
    logic [31:0] count_wr_val;
    logic [15:0] prescale_wr_val;
    logic [31:0] rd_mux;

    // Only the word offset is decoded; the SoC decoder has already qualified the rest.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{iomem_addr[31:5], iomem_addr[1:0]};

    // Bus FSM: accept in IDLE, spend exactly one cycle in ACK, so ready can never
    // be high on two consecutive cycles even if valid stays asserted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        do_access = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (iomem_valid) begin
                    do_access = 1'b1;
                    state_d   = S_ACK;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign iomem_ready = (state_q == S_ACK);
    assign iomem_rdata = rdata_q;
    assign irq_o       = pending_q & ctrl_irq_en_q;

    // Write decode and byte-strobe merge.
    assign reg_sel  = iomem_addr[4:2];
    assign do_write = do_access && (iomem_wstrb != 4'b0000);
    assign wmask    = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                       {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};

    assign wr_ctrl     = do_write && (reg_sel == REG_CTRL) && iomem_wstrb[0];
    assign wr_load     = do_write && (reg_sel == REG_LOAD);
    assign wr_count    = do_write && (reg_sel == REG_COUNT);
    assign wr_prescale = do_write && (reg_sel == REG_PRESCALE) && (iomem_wstrb[1:0] != 2'b00);
    assign clr_pending = do_write && (reg_sel == REG_STATUS) && iomem_wstrb[0] && iomem_wdata[0];

    assign load_wr_val     = (load_q & ~wmask) | (iomem_wdata & wmask);
    assign count_wr_val    = (count_q & ~wmask) | (iomem_wdata & wmask);
    assign prescale_wr_val = (prescale_q & ~wmask[15:0]) | (iomem_wdata[15:0] & wmask[15:0]);

    // A fresh enable restarts the prescale phase so the first tick is a full period away.
    assign en_rise = wr_ctrl && iomem_wdata[0] && !ctrl_en_q;

    // If PRESCALE is lowered below the running pcnt, pcnt wraps through 16 bits
    // before it matches again; firmware reprograms PRESCALE with EN=0.
    assign tick   = ctrl_en_q && (pcnt_q == prescale_q);
    assign expire = tick && (count_q == 32'd0);

    always_comb begin
        rd_mux = 32'd0;
        case (reg_sel)
            REG_CTRL:     rd_mux = {29'd0, ctrl_irq_en_q, ctrl_periodic_q, ctrl_en_q};
            REG_LOAD:     rd_mux = load_q;
            REG_COUNT:    rd_mux = count_q;
            REG_STATUS:   rd_mux = {31'd0, pending_q};
            REG_PRESCALE: rd_mux = {16'd0, prescale_q};
            REG_CYCLES:   rd_mux = cycles_q;
            default:      rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_en_q       <= 1'b0;
            ctrl_periodic_q <= 1'b0;
            ctrl_irq_en_q   <= 1'b0;
            load_q          <= 32'd0;
            count_q         <= 32'd0;
            pending_q       <= 1'b0;
            prescale_q      <= PRESCALE_RESET;
            pcnt_q          <= 16'd0;
            cycles_q        <= 32'd0;
            rdata_q         <= 32'd0;
        end else begin
            cycles_q <= cycles_q + 32'd1;

            if (en_rise) begin
                pcnt_q <= 16'd0;
            end else if (ctrl_en_q) begin
                pcnt_q <= tick ? 16'd0 : pcnt_q + 16'd1;
            end

            // An explicit CTRL write takes precedence over the one-shot auto-disable.
            if (wr_ctrl) begin
                ctrl_en_q       <= iomem_wdata[0];
                ctrl_periodic_q <= iomem_wdata[1];
                ctrl_irq_en_q   <= iomem_wdata[2];
            end else if (expire && !ctrl_periodic_q) begin
                ctrl_en_q <= 1'b0;
            end

            if (wr_load) begin
                load_q <= load_wr_val;
            end

            // A firmware COUNT write beats the tick; reload reads the pre-write LOAD.
            if (wr_count) begin
                count_q <= count_wr_val;
            end else if (tick) begin
                if (count_q != 32'd0) begin
                    count_q <= count_q - 32'd1;
                end else if (ctrl_periodic_q) begin
                    count_q <= load_q;
                end
            end

            // Expiry beats a simultaneous W1C so no timeout is ever lost.
            if (expire) begin
                pending_q <= 1'b1;
            end else if (clr_pending) begin
                pending_q <= 1'b0;
            end

            if (wr_prescale) begin
                prescale_q <= prescale_wr_val;
            end

            rdata_q <= do_access ? rd_mux : 32'd0;
        end
    end

endmodule
